// File: rtl/rv32i_pkg.sv
// Shared types and defaults for the RV32I boot path.
// The loader FSM state type lives here so a testbench or debug logic can decode it.
package rv32i_pkg;

  localparam int IMEM_DEPTH_DEFAULT = 256;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    RUN,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Packs little-endian bytes into 32-bit words; word_vld_o fires combinationally with the 4th byte.
// Zero latency, no backpressure: every byte_vld_i is consumed.
module word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_dat_i,
  output logic        word_vld_o,
  output logic [31:0] word_dat_o
);

  logic [1:0]  lane_q;
  logic [23:0] shift_q;

  // The 4th byte completes the word directly, so only the three older bytes need storage.
  assign word_vld_o = byte_vld_i && (lane_q == 2'd3);
  assign word_dat_o = {byte_dat_i, shift_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q  <= 2'd0;
      shift_q <= 24'd0;
    end else if (byte_vld_i) begin
      lane_q  <= lane_q + 2'd1;
      shift_q <= word_dat_o[31:8];
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory, then releases the CPU.
// One-cycle registered write per word; s_ready drops in RUN/ERROR until start.
module prog_loader
  import rv32i_pkg::*;
#(
  parameter int IMEM_DEPTH = IMEM_DEPTH_DEFAULT,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  input  logic              start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              error
);

  localparam logic [16:0] DEPTH_W = 17'(IMEM_DEPTH);

  loader_state_t     state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic [7:0]        xor_q, xor_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_rst_n_q;

  logic        xfer;
  logic        word_vld;
  logic [31:0] word_dat;

  assign s_ready = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                   (state_q == DATA)   || (state_q == CHECK);
  assign xfer    = s_valid && s_ready;

  word_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_vld_i (xfer && (state_q == DATA)),
    .byte_dat_i (s_data),
    .word_vld_o (word_vld),
    .word_dat_o (word_dat)
  );

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_cnt_d   = word_cnt_q;
    xor_d        = xor_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    case (state_q)
      LEN_LO: begin
        word_cnt_d = 16'd0;
        xor_d      = 8'd0;
        if (xfer) begin
          len_d   = {8'h00, s_data};
          state_d = LEN_HI;
        end
      end
      LEN_HI: begin
        if (xfer) begin
          len_d = {s_data, len_q[7:0]};
          if ({1'b0, len_d} > DEPTH_W) state_d = ERROR;
          else if (len_d == 16'd0)     state_d = CHECK;
          else                         state_d = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          xor_d = xor_q ^ s_data;
          if (word_vld) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_cnt_q[ADDR_W-1:0];
            imem_wdata_d = word_dat;
            word_cnt_d   = word_cnt_q + 16'd1;
            if (word_cnt_d == len_q) state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (xfer) state_d = (s_data == xor_q) ? RUN : ERROR;
      end
      RUN, ERROR: begin
        if (start) state_d = LEN_LO;
      end
      default: state_d = LEN_LO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LEN_LO;
      len_q        <= 16'd0;
      word_cnt_q   <= 16'd0;
      xor_q        <= 8'd0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
      cpu_rst_n_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_cnt_q   <= word_cnt_d;
      xor_q        <= xor_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      // Tracks the next state so the core is held in reset on the same edge that leaves RUN.
      cpu_rst_n_q  <= (state_d == RUN);
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_rst_n  = cpu_rst_n_q;
  assign done       = (state_q == RUN);
  assign error      = (state_q == ERROR);

endmodule

// File: tb/tb_prog_loader.sv
// Randomized stream bench for prog_loader with a byte-stream reference model.
module tb_prog_loader;

  localparam int DEPTH = 256;

  typedef logic [7:0]  bq_t[$];
  typedef logic [39:0] wq_t[$];
  typedef logic [31:0] lq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'd0;
  logic        start = 1'b0;
  logic        s_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst_n;
  logic        done;
  logic        error;

  int n_err = 0;
  int n_chk = 0;
  wq_t obs_q;

  prog_loader #(.IMEM_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .start      (start),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst_n  (cpu_rst_n),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && imem_we) obs_q.push_back({imem_addr, imem_wdata});

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected behaviour straight from the stream format: length, LE words, XOR checksum.
  task automatic model(input bq_t b, output wq_t exp_w, output bit ok, output int used);
    int n;
    logic [7:0] x;
    logic [31:0] w;
    exp_w = {};
    n = int'({b[1], b[0]});
    if (n > DEPTH) begin
      ok = 1'b0;
      used = 2;
      return;
    end
    x = 8'd0;
    for (int i = 0; i < n; i++) begin
      w = 32'(b[2+4*i]) + (32'(b[3+4*i]) << 8) + (32'(b[4+4*i]) << 16) + (32'(b[5+4*i]) << 24);
      exp_w.push_back({8'(i), w});
      for (int k = 0; k < 4; k++) x = x ^ b[2+4*i+k];
    end
    ok = (b[2+4*n] == x);
    used = 3 + 4*n;
  endtask

  task automatic build(input int n, input lq_t ws, input bit bad, output bq_t b);
    logic [7:0] cx;
    logic [7:0] by;
    logic [15:0] n16;
    n16 = 16'(n);
    b = {};
    b.push_back(n16[7:0]);
    b.push_back(n16[15:8]);
    cx = 8'd0;
    foreach (ws[i]) begin
      for (int k = 0; k < 4; k++) begin
        by = 8'(ws[i] >> (8*k));
        b.push_back(by);
        cx = cx ^ by;
      end
    end
    b.push_back(bad ? (cx ^ 8'(1 + $urandom_range(0, 254))) : cx);
  endtask

  // Random idle gaps, and random start pulses that must be ignored while loading.
  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    start   = ($urandom_range(0, 3) == 0);
    for (int t = 0; t < 20 && !s_ready; t++) @(negedge clk);
    if (!s_ready) chk_eq("ready_timeout", 64'(s_ready), 64'd1);
    else @(posedge clk);
    #1;
    s_valid = 1'b0;
    start   = 1'b0;
  endtask

  task automatic run_load(input string tag, input bq_t b);
    wq_t exp_w;
    bit ok;
    int used;
    int m;
    model(b, exp_w, ok, used);
    obs_q.delete();
    for (int i = 0; i < used; i++) send_byte(b[i]);
    repeat (3) @(negedge clk);
    chk_eq({tag, "_nwr"}, 64'(obs_q.size()), 64'(exp_w.size()));
    m = (obs_q.size() < exp_w.size()) ? obs_q.size() : exp_w.size();
    for (int i = 0; i < m; i++) chk_eq({tag, "_wr"}, 64'(obs_q[i]), 64'(exp_w[i]));
    chk_eq({tag, "_done"},  64'(done),      64'(ok));
    chk_eq({tag, "_error"}, 64'(error),     64'(!ok));
    chk_eq({tag, "_cpu"},   64'(cpu_rst_n), 64'(ok));
    chk_eq({tag, "_rdy"},   64'(s_ready),   64'd0);
  endtask

  task automatic pulse_start(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk_eq({tag, "_rdy"},  64'(s_ready),   64'd1);
    chk_eq({tag, "_done"}, 64'(done),      64'd0);
    chk_eq({tag, "_err"},  64'(error),     64'd0);
    chk_eq({tag, "_cpu"},  64'(cpu_rst_n), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bq_t b;
    lq_t ws;
    #3;
    chk_eq("rst_rdy",   64'(s_ready),    64'd1);
    chk_eq("rst_we",    64'(imem_we),    64'd0);
    chk_eq("rst_addr",  64'(imem_addr),  64'd0);
    chk_eq("rst_wdata", 64'(imem_wdata), 64'd0);
    chk_eq("rst_cpu",   64'(cpu_rst_n),  64'd0);
    chk_eq("rst_done",  64'(done),       64'd0);
    chk_eq("rst_err",   64'(error),      64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    b = {8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h44};
    run_load("one_word", b);
    pulse_start("st1");

    ws = {32'h00C02903, 32'h01202823, 32'h01402883};
    build(3, ws, 1'b0, b);
    run_load("three_words", b);
    pulse_start("st2");

    b = {8'h00, 8'h00, 8'h00};
    run_load("n0_ok", b);
    pulse_start("st3");
    b = {8'h00, 8'h00, 8'h5A};
    run_load("n0_bad", b);
    pulse_start("st4");

    b = {8'h01, 8'h01};
    run_load("len257", b);
    pulse_start("st5");

    b = {8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h45};
    run_load("bad_sum", b);
    pulse_start("st6");
    b = {8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h44};
    run_load("reload", b);
    pulse_start("st7");

    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 16);
      ws = {};
      for (int i = 0; i < n; i++) ws.push_back($urandom);
      build(n, ws, ($urandom_range(0, 3) == 0), b);
      run_load("rand", b);
      pulse_start("st_rand");
    end

    ws = {};
    for (int i = 0; i < DEPTH; i++) ws.push_back($urandom);
    build(DEPTH, ws, 1'b0, b);
    run_load("full_depth", b);
    pulse_start("st8");

    b = {8'hFF, 8'hFF};
    run_load("len_ffff", b);
    pulse_start("st9");

    obs_q.delete();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("mid_we",    64'(imem_we),    64'd0);
    chk_eq("mid_addr",  64'(imem_addr),  64'd0);
    chk_eq("mid_wdata", 64'(imem_wdata), 64'd0);
    chk_eq("mid_cpu",   64'(cpu_rst_n),  64'd0);
    chk_eq("mid_done",  64'(done),       64'd0);
    chk_eq("mid_err",   64'(error),      64'd0);
    chk_eq("mid_rdy",   64'(s_ready),    64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    chk_eq("mid_nwr", 64'(obs_q.size()), 64'd0);
    ws = {32'hDEADBEEF, 32'h12345678};
    build(2, ws, 1'b0, b);
    run_load("after_rst", b);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
